plru_replacement_ctrl: RTL and testbench

PLRU_REPLACEMENT_CTRL -- requirements
Module: plru_replacement_ctrl

---
 rtl/plru_replacement_ctrl.sv | 107 ++++++++++
 tb/tb_plru_replacement_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/plru_replacement_ctrl.sv
// Tree-PLRU replacement controller: per-set NUM_WAYS-1 bit trees, hit/miss updates, victim selection,
// and a one-set-per-cycle flush. Response registered one cycle after acceptance; requests stall during flush.
module plru_replacement_ctrl #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_SETS)-1:0] req_set,
  input  logic                        req_hit,
  input  logic [$clog2(NUM_WAYS)-1:0] req_hit_way,
  output logic                        resp_valid,
  output logic [$clog2(NUM_WAYS)-1:0] resp_way,
  output logic [$clog2(NUM_SETS)-1:0] resp_set,
  input  logic                        flush_req,
  output logic                        flush_done
);

  localparam int WW    = $clog2(NUM_WAYS);
  localparam int SW    = $clog2(NUM_SETS);
  localparam int NODES = NUM_WAYS - 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [SW-1:0]    flush_cnt;
  logic [NODES-1:0] tree [NUM_SETS];
  logic [NODES-1:0] cur_tree;
  logic [WW-1:0]    acc_way;

  // Node bit 1 points at the left (lower) half as the LRU side.
  function automatic logic [WW-1:0] lru_way(input logic [NODES-1:0] t);
    int node;
    lru_way = '0;
    node    = 0;
    for (int l = 0; l < WW; l++) begin
      if (t[node]) begin
        lru_way[WW-1-l] = 1'b0;
        node            = 2*node + 1;
      end else begin
        lru_way[WW-1-l] = 1'b1;
        node            = 2*node + 2;
      end
    end
  endfunction

  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t, input logic [WW-1:0] w);
    int node;
    touch = t;
    node  = 0;
    for (int l = 0; l < WW; l++) begin
      if (w[WW-1-l]) begin
        touch[node] = 1'b1;
        node        = 2*node + 2;
      end else begin
        touch[node] = 1'b0;
        node        = 2*node + 1;
      end
    end
  endfunction

  assign cur_tree  = tree[req_set];
  assign acc_way   = req_hit ? req_hit_way : lru_way(cur_tree);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '1;
      state      <= IDLE;
      flush_cnt  <= '0;
      resp_valid <= 1'b0;
      resp_way   <= '0;
      resp_set   <= '0;
      flush_done <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tree[req_set] <= touch(cur_tree, acc_way);
            resp_valid    <= 1'b1;
            resp_way      <= acc_way;
            resp_set      <= req_set;
          end
          // A same-cycle access still completes; the flush overwrites it later.
          if (flush_req) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          tree[flush_cnt] <= '1;
          flush_cnt       <= flush_cnt + SW'(1);
          if (flush_cnt == SW'(NUM_SETS - 1)) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_replacement_ctrl.sv
// Self-checking bench: interval-based PLRU reference model compared every cycle, plus directed literal checks.
module tb_plru_replacement_ctrl;
  localparam int NW = 8;
  localparam int NS = 16;
  localparam int WW = $clog2(NW);
  localparam int SW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SW-1:0] req_set = '0;
  logic          req_hit = 1'b0;
  logic [WW-1:0] req_hit_way = '0;
  logic          resp_valid;
  logic [WW-1:0] resp_way;
  logic [SW-1:0] resp_set;
  logic          flush_req = 1'b0;
  logic          flush_done;

  int tests = 0;
  int fails = 0;

  plru_replacement_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_hit(req_hit), .req_hit_way(req_hit_way),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_set(resp_set),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tree bits per node, walked as halving way intervals.
  bit m_tree [NS][NW-1];
  bit m_flushing;
  int m_cnt;
  bit exp_valid, exp_done;
  int exp_way, exp_set;

  function automatic int m_lru(input int s);
    int node = 0, lo = 0, size = NW;
    while (size > 1) begin
      if (m_tree[s][node]) node = 2*node + 1;
      else begin lo += size/2; node = 2*node + 2; end
      size /= 2;
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int node = 0, lo = 0, size = NW;
    while (size > 1) begin
      if (w < lo + size/2) begin m_tree[s][node] = 1'b0; node = 2*node + 1; end
      else begin m_tree[s][node] = 1'b1; lo += size/2; node = 2*node + 2; end
      size /= 2;
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NW-1; n++) m_tree[s][n] = 1'b1;
    m_flushing = 1'b0; m_cnt = 0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_way = 0; exp_set = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (!m_flushing) begin
        if (req_valid) begin
          exp_way = req_hit ? int'(req_hit_way) : m_lru(int'(req_set));
          exp_set = int'(req_set);
          m_touch(exp_set, exp_way);
          exp_valid = 1'b1;
        end
        if (flush_req) begin m_flushing = 1'b1; m_cnt = 0; end
      end else begin
        for (int n = 0; n < NW-1; n++) m_tree[m_cnt][n] = 1'b1;
        m_cnt++;
        if (m_cnt == NS) begin m_flushing = 1'b0; exp_done = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    check("model_ready", int'(req_ready), int'(!m_flushing));
    check("model_resp_valid", int'(resp_valid), int'(exp_valid));
    check("model_flush_done", int'(flush_done), int'(exp_done));
    if (exp_valid) begin
      check("model_resp_way", int'(resp_way), exp_way);
      check("model_resp_set", int'(resp_set), exp_set);
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic do_req(input string name, input int s, input bit hit, input int way, input int exp);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_set = SW'(s); req_hit = hit; req_hit_way = WW'(way);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({name, "_ready_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({name, "_valid"}, int'(resp_valid), 1);
    check({name, "_way"}, int'(resp_way), exp);
    check({name, "_set"}, int'(resp_set), s);
  endtask

  task automatic wait_flush(input string name, output int n, output int dones);
    n = 0; dones = 0;
    while (!req_ready && n < 100) begin
      if (flush_done) dones++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int n, dones;
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(req_ready), 1);
    check("reset_resp_valid", int'(resp_valid), 0);
    check("reset_resp_way", int'(resp_way), 0);
    check("reset_resp_set", int'(resp_set), 0);
    check("reset_flush_done", int'(flush_done), 0);

    for (int i = 0; i < 8; i++) do_req($sformatf("miss8_%0d", i), 3, 1'b0, 0, seq[i]);
    do_req("other_set5", 5, 1'b0, 0, 0);
    do_req("wrap_set3", 3, 1'b0, 0, 0);

    do_reset();
    do_req("hit_w0", 3, 1'b1, 0, 0);
    do_req("miss_after_w0", 3, 1'b0, 0, 4);
    do_req("hit_w4", 3, 1'b1, 4, 4);
    do_req("miss_after_w4", 3, 1'b0, 0, 2);

    // Flush with a request held pending throughout.
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    req_valid = 1'b1; req_set = SW'(3); req_hit = 1'b0;
    wait_flush("flush", n, dones);
    check("flush_cycles", n, 16);
    check("flush_done_at_end", int'(flush_done), 1);
    check("flush_done_early", dones, 0);
    @(posedge clk); #1; req_valid = 1'b0;
    check("post_flush_valid", int'(resp_valid), 1);
    check("post_flush_way", int'(resp_way), 0);

    // Reset in the middle of a flush.
    do_req("pre_abort", 9, 1'b0, 0, 0);
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(req_ready), 1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    do_req("abort_miss9", 9, 1'b0, 0, 0);

    // Flush and an accepted miss in the same cycle.
    @(negedge clk);
    flush_req = 1'b1; req_valid = 1'b1; req_set = SW'(2); req_hit = 1'b0;
    @(posedge clk); #1;
    flush_req = 1'b0; req_valid = 1'b0;
    check("same_cycle_valid", int'(resp_valid), 1);
    check("same_cycle_way", int'(resp_way), 0);
    @(negedge clk);
    wait_flush("flush2", n, dones);
    check("flush2_cycles", n, 16);
    check("flush2_done", int'(flush_done), 1);
    do_req("after_flush2_set2", 2, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
